// File: rtl/cond_sum_subtractor_8bit_pipe_if.sv
// ---------------------------------------------------------------------------
// cond_sum_subtractor_8bit_pipe_if
//
// Operand/result bundle for the pipelined 8-bit conditional-sum subtractor.
//
// Handshake: a transfer on either side happens on a rising clk edge where
// the producer's valid and the consumer's ready are both high. A producer
// holding valid high keeps its payload stable until the transfer; ready
// may be asserted regardless of valid and never depends on valid in the
// same cycle.
//
// Signals:
//   A, B, Bin          operand set (minuend, subtrahend, borrow-in)
//   in_valid/in_ready  input-side handshake
//   Diff, Bout, Ovf    result (difference, borrow-out, signed overflow)
//   out_valid/out_ready output-side handshake
//
// Modports:
//   master  operand source / result sink (e.g. testbench or upstream logic)
//   slave   the subtractor itself
// ---------------------------------------------------------------------------
interface cond_sum_subtractor_8bit_pipe_if;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] Diff;
    logic       Bout;
    logic       Ovf;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output A, B, Bin, in_valid, out_ready,
        input  in_ready, Diff, Bout, Ovf, out_valid
    );

    modport slave (
        input  A, B, Bin, in_valid, out_ready,
        output in_ready, Diff, Bout, Ovf, out_valid
    );
endinterface

// File: rtl/cond_sum_subtractor_8bit_pipe.sv
// ---------------------------------------------------------------------------
// cond_sum_subtractor_8bit_pipe
//
// Two-stage pipelined 8-bit subtractor using the conditional-sum principle.
// Computes Diff = (A - B - Bin) mod 256, Bout = unsigned borrow-out and
// Ovf = two's-complement overflow.
//
//   Stage 1: low-nibble difference with Bin, plus both high-nibble
//            candidates (borrow-in 0 and borrow-in 1), each with its own
//            borrow-out and overflow bit. Everything registered.
//   Stage 2: pure selection of the high candidate by the registered
//            low-nibble borrow, then registered as the result.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  slave side of cond_sum_subtractor_8bit_pipe_if
//
// Flow control: each stage advances when it is empty or when the stage
// after it is advancing, so a full pipe with out_ready high accepts,
// moves and drains on the same edge. in_ready depends only on the stage
// valid bits and out_ready.
// ---------------------------------------------------------------------------
module cond_sum_subtractor_8bit_pipe (
    input  logic                                  clk,
    input  logic                                  rst,
    cond_sum_subtractor_8bit_pipe_if.slave        bus
);

    // 4-bit ripple subtract x - y - bi; bit 4 of the result is the borrow.
    // Only nibble-wide ripples exist; the 8-bit result is built by selection.
    function automatic logic [4:0] nib_sub(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       bi);
        logic [4:0] r;
        logic       br;
        br = bi;
        r  = '0;
        for (int i = 0; i < 4; i++) begin
            r[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        r[4] = br;
        return r;
    endfunction

    // ---------------------------------------------------------------
    // Flow control
    // ---------------------------------------------------------------
    logic v1;
    logic v2;
    logic s1_take;
    logic s2_take;
    logic in_fire;

    assign s2_take      = !v2 || bus.out_ready;
    assign s1_take      = !v1 || s2_take;
    assign bus.in_ready = s1_take;
    assign in_fire      = bus.in_valid && s1_take;

    // ---------------------------------------------------------------
    // Stage 1 combinational: low nibble and both high candidates
    // ---------------------------------------------------------------
    logic [4:0] lo_c;
    logic [4:0] h0_c;
    logic [4:0] h1_c;
    logic       h0_ovf_c;
    logic       h1_ovf_c;
    logic       sign_differs;

    always_comb begin
        lo_c = nib_sub(bus.A[3:0], bus.B[3:0], bus.Bin);
        h0_c = nib_sub(bus.A[7:4], bus.B[7:4], 1'b0);
        h1_c = nib_sub(bus.A[7:4], bus.B[7:4], 1'b1);
    end

    // Overflow only possible when operand signs differ; it happens when the
    // result sign disagrees with the minuend sign. Evaluated per candidate
    // because the candidates can have different result signs.
    assign sign_differs = bus.A[7] ^ bus.B[7];
    assign h0_ovf_c     = sign_differs && (h0_c[3] != bus.A[7]);
    assign h1_ovf_c     = sign_differs && (h1_c[3] != bus.A[7]);

    // ---------------------------------------------------------------
    // Stage 1 registers
    // ---------------------------------------------------------------
    logic [3:0] s1_lo;
    logic       s1_b4;
    logic [3:0] s1_h0;
    logic       s1_h0_b;
    logic       s1_h0_ovf;
    logic [3:0] s1_h1;
    logic       s1_h1_b;
    logic       s1_h1_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            s1_lo     <= '0;
            s1_b4     <= 1'b0;
            s1_h0     <= '0;
            s1_h0_b   <= 1'b0;
            s1_h0_ovf <= 1'b0;
            s1_h1     <= '0;
            s1_h1_b   <= 1'b0;
            s1_h1_ovf <= 1'b0;
        end else if (s1_take) begin
            v1 <= bus.in_valid;
            if (in_fire) begin
                s1_lo     <= lo_c[3:0];
                s1_b4     <= lo_c[4];
                s1_h0     <= h0_c[3:0];
                s1_h0_b   <= h0_c[4];
                s1_h0_ovf <= h0_ovf_c;
                s1_h1     <= h1_c[3:0];
                s1_h1_b   <= h1_c[4];
                s1_h1_ovf <= h1_ovf_c;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: selection only, driven by the low-nibble borrow
    // ---------------------------------------------------------------
    logic [3:0] hsel;
    logic       bsel;
    logic       osel;

    always_comb begin
        hsel = s1_b4 ? s1_h1     : s1_h0;
        bsel = s1_b4 ? s1_h1_b   : s1_h0_b;
        osel = s1_b4 ? s1_h1_ovf : s1_h0_ovf;
    end

    logic [7:0] diff_q;
    logic       bout_q;
    logic       ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2     <= 1'b0;
            diff_q <= 8'h00;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (s2_take) begin
            v2 <= v1;
            if (v1) begin
                diff_q <= {hsel, s1_lo};
                bout_q <= bsel;
                ovf_q  <= osel;
            end
        end
    end

    assign bus.Diff      = diff_q;
    assign bus.Bout      = bout_q;
    assign bus.Ovf       = ovf_q;
    assign bus.out_valid = v2;

endmodule

// File: tb/tb_cond_sum_subtractor_8bit_pipe.sv
// ---------------------------------------------------------------------------
// tb_cond_sum_subtractor_8bit_pipe
//
// Self-checking bench: reset values, a table of hand-computed vectors with
// latency/pulse checks, a stalled back-to-back stream, a mid-cycle reset,
// and a random stream with random back-pressure against a reference model.
// Inputs are driven 1 ns after the rising edge; outputs sampled there too.
// ---------------------------------------------------------------------------
module tb_cond_sum_subtractor_8bit_pipe;

    logic clk;
    logic rst;

    cond_sum_subtractor_8bit_pipe_if bus ();

    cond_sum_subtractor_8bit_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [9:0] exp_q[$];   // {Bout, Ovf, Diff}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bi);
        int         d;
        logic [7:0] df;
        logic       bo;
        logic       ov;
        d  = int'(a) - int'(b) - int'(bi);
        df = d[7:0];
        bo = (d < 0);
        ov = (a[7] != b[7]) && (df[7] != a[7]);
        return {bo, ov, df};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pipe empty, out_ready high: present, accept on the next edge, result
    // visible after the following edge, gone after one more.
    task automatic apply_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic bi, input logic [7:0] ed, input logic eb, input logic eo);
        bus.A = a; bus.B = b; bus.Bin = bi;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check({name, "_early"}, 32'(bus.out_valid), 32'd0);
        tick();
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_diff"},  32'(bus.Diff), 32'(ed));
        check({name, "_bout"},  32'(bus.Bout), 32'(eb));
        check({name, "_ovf"},   32'(bus.Ovf),  32'(eo));
        tick();
        check({name, "_pulse"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic check_out(input string name, input logic [7:0] ed, input logic eb, input logic eo);
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_diff"},  32'(bus.Diff), 32'(ed));
        check({name, "_bout"},  32'(bus.Bout), 32'(eb));
        check({name, "_ovf"},   32'(bus.Ovf),  32'(eo));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [7:0] ra, rb;
        logic       rbin;
        logic       pending;
        logic       prev_stall;
        logic [10:0] prev_out;
        int         sent, got, cycles;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h0E, 1'b0, 1'b0};
        vecs[1] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h37, 8'h12, 1'b1, 8'h24, 1'b0, 1'b0};
        vecs[8] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[9] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};

        // ---- reset state ----
        rst = 1'b1;
        bus.A = 8'h00; bus.B = 8'h00; bus.Bin = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_diff",      32'(bus.Diff), 32'h00);
        check("rst_bout",      32'(bus.Bout), 32'd0);
        check("rst_ovf",       32'(bus.Ovf),  32'd0);
        check("rst_in_ready",  32'(bus.in_ready), 32'd1);
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // ---- table-driven vectors ----
        for (int i = 0; i < 10; i++) begin
            apply_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                      vecs[i].diff, vecs[i].bout, vecs[i].ovf);
        end

        // ---- stalled back-to-back stream ----
        bus.out_ready = 1'b0;
        bus.A = 8'h55; bus.B = 8'h2A; bus.Bin = 1'b0; bus.in_valid = 1'b1;
        tick();                                   // accept #1
        check("strm_ready1", 32'(bus.in_ready), 32'd1);
        bus.A = 8'hAA; bus.B = 8'h55; bus.Bin = 1'b1;
        tick();                                   // accept #2, #1 at output
        check_out("strm_hold0", 8'h2B, 1'b0, 1'b0);
        check("strm_full_ready", 32'(bus.in_ready), 32'd0);
        bus.A = 8'h01; bus.B = 8'h02; bus.Bin = 1'b0;
        tick();
        check_out("strm_hold1", 8'h2B, 1'b0, 1'b0);
        check("strm_full_ready2", 32'(bus.in_ready), 32'd0);
        tick();
        check_out("strm_hold2", 8'h2B, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        check("strm_release_ready", 32'(bus.in_ready), 32'd1);
        tick();                                   // consume, move, accept #3 together
        bus.in_valid = 1'b0;
        check_out("strm_out1", 8'h54, 1'b0, 1'b1);
        tick();
        check_out("strm_out2", 8'hFF, 1'b1, 1'b0);
        tick();
        check("strm_drained", 32'(bus.out_valid), 32'd0);

        // ---- asynchronous reset with two sets in flight ----
        bus.out_ready = 1'b0;
        bus.A = 8'h80; bus.B = 8'h01; bus.Bin = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.A = 8'h0F; bus.B = 8'h01;
        tick();
        bus.in_valid = 1'b0;
        check("arst_pre_valid", 32'(bus.out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_diff",      32'(bus.Diff), 32'h00);
        check("arst_in_ready",  32'(bus.in_ready), 32'd1);
        tick();
        #2 rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("arst_no_stale", 32'(bus.out_valid), 32'd0);
        end
        apply_vec("arst_next", 8'h37, 8'h12, 1'b1, 8'h24, 1'b0, 1'b0);

        // ---- random stream with random back-pressure ----
        sent = 0; got = 0; cycles = 0;
        pending = 1'b0; prev_stall = 1'b0; prev_out = '0;
        ra = '0; rb = '0; rbin = 1'b0;
        while (got < 256 && cycles < 6000) begin
            if (!pending && sent < 256) begin
                if ($urandom_range(0, 3) != 0) begin
                    ra = 8'($urandom_range(0, 255));
                    rb = 8'($urandom_range(0, 255));
                    rbin = 1'($urandom_range(0, 1));
                    bus.A = ra; bus.B = rb; bus.Bin = rbin;
                    bus.in_valid = 1'b1;
                    pending = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end else if (!pending) begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = (sent >= 256) ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            if (prev_stall)
                check("rand_hold", 32'({bus.out_valid, bus.Bout, bus.Ovf, bus.Diff}), 32'(prev_out));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rand_extra: got 0x%0h expected no result", {bus.Bout, bus.Ovf, bus.Diff});
                end else begin
                    check("rand_result", 32'({bus.Bout, bus.Ovf, bus.Diff}), 32'(exp_q.pop_front()));
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(ra, rb, rbin));
                sent++;
                pending = 1'b0;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_valid, bus.Bout, bus.Ovf, bus.Diff};
            tick();
            cycles++;
        end
        bus.in_valid = 1'b0;
        check("rand_count", 32'(got), 32'd256);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
